// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: program/data memory request-ack bus; the sequencer is master, memories are slave.
interface alu_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] pm_addr;
    logic                pm_rd;
    logic [WIDTH-1:0]    pm_data;
    logic                pm_valid;
    logic [WIDTH-1:0]    dm_addr;
    logic                dm_rd;
    logic                dm_wr;
    logic [WIDTH-1:0]    dm_wdata;
    logic [WIDTH-1:0]    dm_rdata;
    logic                dm_valid;
    modport master (
        output pm_addr, pm_rd, dm_addr, dm_rd, dm_wr, dm_wdata,
        input  pm_data, pm_valid, dm_rdata, dm_valid
    );
    modport slave (
        input  pm_addr, pm_rd, dm_addr, dm_rd, dm_wr, dm_wdata,
        output pm_data, pm_valid, dm_rdata, dm_valid
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/operand/store control unit feeding IR/IBR/MBR and Exec to the ALU.
// Define SEQ_RETIRE_CNT_EN to add the 16-bit retired-instruction counter port.
module alu_sequencer #(
    parameter int               WIDTH    = 8,
    parameter int               PC_WIDTH = 8,
    parameter logic [WIDTH-1:0] HALT_OP  = 8'hFF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             run,
    alu_sequencer_if.master  bus,
    input  logic [WIDTH-1:0] AR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] IBR,
    output logic [WIDTH-1:0] MBR,
    output logic             Exec,
    output logic             halted
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]      retired
`endif
);
    // Opcode map: 0x30/0x31 stores, 0x2x loads (bit0 selects memory operand), others ALU (bit3 selects memory operand).
    localparam logic [WIDTH-1:0] STORE_X       = 8'h30;
    localparam logic [WIDTH-1:0] STORE_I       = 8'h31;
    localparam logic [3:0]       LOAD_GRP      = 4'h2;
    localparam int               MOV_OPER2_BIT = 0;
    localparam int               ALU_OPER2_BIT = 3;
    localparam logic             OPER2_X       = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_OP, S_FETCH_IMM, S_MEM_RD, S_MEM_WR, S_EXEC, S_HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                is_store;
    logic                mem_oper;

    assign bus.pm_addr = pc;
    assign bus.dm_addr = IBR;
    assign is_store    = IR == STORE_X || IR == STORE_I;
    assign mem_oper    = (IR[7:4] == LOAD_GRP ? IR[MOV_OPER2_BIT] : IR[ALU_OPER2_BIT]) == OPER2_X;

    always_ff @(posedge clk) begin
        if (arst) begin
            state        <= S_IDLE;
            pc           <= '0;
            IR           <= '0;
            IBR          <= '0;
            MBR          <= '0;
            bus.dm_wdata <= '0;
            bus.pm_rd    <= 1'b0;
            bus.dm_rd    <= 1'b0;
            bus.dm_wr    <= 1'b0;
            Exec         <= 1'b0;
            halted       <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
            retired      <= '0;
`endif
        end else begin
            Exec <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
            if (Exec || (state == S_MEM_WR && bus.dm_valid)) retired <= retired + 16'd1;
`endif
            case (state)
                S_IDLE: begin
                    state     <= run ? S_FETCH_OP : S_IDLE;
                    bus.pm_rd <= run;
                end
                S_FETCH_OP: if (bus.pm_valid) begin
                    IR    <= bus.pm_data;
                    pc    <= pc + PC_WIDTH'(1);
                    state <= S_FETCH_IMM;
                end
                S_FETCH_IMM: if (bus.pm_valid) begin
                    IBR       <= bus.pm_data;
                    pc        <= pc + PC_WIDTH'(1);
                    bus.pm_rd <= 1'b0;
                    if (IR == HALT_OP) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (is_store) begin
                        state        <= S_MEM_WR;
                        bus.dm_wr    <= 1'b1;
                        bus.dm_wdata <= AR;
                    end else if (mem_oper) begin
                        state     <= S_MEM_RD;
                        bus.dm_rd <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                        Exec  <= 1'b1;
                    end
                end
                S_MEM_RD: if (bus.dm_valid) begin
                    MBR       <= bus.dm_rdata;
                    bus.dm_rd <= 1'b0;
                    state     <= S_EXEC;
                    Exec      <= 1'b1;
                end
                // Completion of a store or an execute falls straight into the next fetch while run holds.
                S_MEM_WR: if (bus.dm_valid) begin
                    bus.dm_wr <= 1'b0;
                    state     <= run ? S_FETCH_OP : S_IDLE;
                    bus.pm_rd <= run;
                end
                S_EXEC: begin
                    state     <= run ? S_FETCH_OP : S_IDLE;
                    bus.pm_rd <= run;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scenarios plus a random program checked against a transaction-level model.
module tb_alu_sequencer;
    localparam int K_PM = 0, K_RD = 1, K_WR = 2, K_EX = 3, K_HALT = 4;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] ir;
        logic [7:0] ibr;
        logic [7:0] mbr;
    } ev_t;

    logic       clk = 0;
    logic       arst = 1;
    logic       run = 0;
    logic [7:0] AR = 0;
    logic [7:0] IR, IBR, MBR;
    logic       Exec, halted;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    alu_sequencer_if #(.WIDTH(8), .PC_WIDTH(8)) bus ();

    alu_sequencer dut (
        .clk(clk), .arst(arst), .run(run), .bus(bus), .AR(AR),
        .IR(IR), .IBR(IBR), .MBR(MBR), .Exec(Exec), .halted(halted)
`ifdef SEQ_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] pm_mem [256];
    logic [7:0] dm_mem [256];
    int vectors = 0, errors = 0;
    int pm_fix = 0, dm_fix = 0, pm_d = 0, dm_d = 0, pm_w = 0, dm_w = 0;
    bit spur = 0, ar_fix = 1, mon_en = 0;
    logic [7:0] ar_val = 8'hA5;

    ev_t q[$];
    logic [7:0] pc_m, mbr_m;
    bit m_halt, halt_seen;
    int cyc, last_ack, ret_m;
    logic p_pm_rd, p_pm_valid, p_dm_rd, p_dm_wr, p_dm_valid;
    logic [7:0] p_pm_addr, p_dm_addr, p_dm_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int fix);
        return fix >= 0 ? fix : int'($urandom_range(0, 3));
    endfunction

    function automatic int head();
        return q.size() > 0 ? q[0].kind : -1;
    endfunction

    // Expected transactions of one instruction, derived from memory contents and the opcode rules.
    task automatic gen();
        logic [7:0] op, opd;
        ev_t e;
        op  = pm_mem[pc_m];
        opd = pm_mem[8'(pc_m + 8'd1)];
        e.kind = K_PM; e.addr = pc_m; e.data = 0; e.ir = 0; e.ibr = 0; e.mbr = 0;
        q.push_back(e);
        e.addr = 8'(pc_m + 8'd1);
        q.push_back(e);
        pc_m = 8'(pc_m + 8'd2);
        if (op == 8'hFF) begin
            e.kind = K_HALT;
            q.push_back(e);
            m_halt = 1;
        end else if (op == 8'h30 || op == 8'h31) begin
            e.kind = K_WR; e.addr = opd;
            q.push_back(e);
        end else begin
            if (op[7:4] == 4'h2 ? op[0] : op[3]) begin
                e.kind = K_RD; e.addr = opd;
                q.push_back(e);
                mbr_m = dm_mem[opd];
            end
            e.kind = K_EX; e.ir = op; e.ibr = opd; e.mbr = mbr_m;
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pc_m = 0; mbr_m = 0; m_halt = 0; halt_seen = 0;
        cyc = 0; last_ack = -10; ret_m = 0;
        p_pm_rd = 0; p_pm_valid = 0; p_dm_rd = 0; p_dm_wr = 0; p_dm_valid = 0;
        p_pm_addr = 0; p_dm_addr = 0; p_dm_wdata = 0;
    endtask

    // Memory responder with programmable wait states and optional stray acks.
    always @(posedge clk) begin
        #1;
        AR = ar_fix ? ar_val : 8'($urandom);
        if (bus.pm_rd === 1'b1) begin
            if (pm_w >= pm_d) begin bus.pm_valid = 1; pm_w = 0; pm_d = pick(pm_fix); end
            else begin bus.pm_valid = 0; pm_w++; end
        end else begin
            bus.pm_valid = spur && ($urandom_range(0, 3) == 0);
            pm_w = 0;
        end
        if (bus.dm_rd === 1'b1 || bus.dm_wr === 1'b1) begin
            if (dm_w >= dm_d) begin bus.dm_valid = 1; dm_w = 0; dm_d = pick(dm_fix); end
            else begin bus.dm_valid = 0; dm_w++; end
        end else begin
            bus.dm_valid = spur && ($urandom_range(0, 3) == 0);
            dm_w = 0;
        end
        bus.pm_data  = pm_mem[bus.pm_addr];
        bus.dm_rdata = dm_mem[bus.dm_addr];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (q.size() == 0 && !m_halt) gen();
            if (p_pm_rd && !p_pm_valid) begin
                chk("pm_rd held", 32'(bus.pm_rd), 1);
                chk("pm_addr held", 32'(bus.pm_addr), 32'(p_pm_addr));
            end
            if ((p_dm_rd || p_dm_wr) && !p_dm_valid) begin
                chk("dm req held", 32'({bus.dm_rd, bus.dm_wr}), 32'({p_dm_rd, p_dm_wr}));
                chk("dm_addr held", 32'(bus.dm_addr), 32'(p_dm_addr));
                if (p_dm_wr) chk("dm_wdata held", 32'(bus.dm_wdata), 32'(p_dm_wdata));
            end
`ifdef SEQ_RETIRE_CNT_EN
            chk("retired", 32'(retired), 32'(ret_m));
`endif
            if (bus.pm_rd && bus.pm_valid) begin
                chk("pm ack kind", 32'(head()), K_PM);
                if (head() == K_PM) begin
                    chk("pm_addr", 32'(bus.pm_addr), 32'(q[0].addr));
                    void'(q.pop_front());
                    last_ack = cyc;
                    if (head() == K_WR) q[0].data = AR;
                end
            end
            if (bus.dm_rd && bus.dm_valid) begin
                chk("dm rd kind", 32'(head()), K_RD);
                if (head() == K_RD) begin
                    chk("dm rd addr", 32'(bus.dm_addr), 32'(q[0].addr));
                    void'(q.pop_front());
                    last_ack = cyc;
                end
            end
            if (bus.dm_wr && bus.dm_valid) begin
                chk("dm wr kind", 32'(head()), K_WR);
                if (head() == K_WR) begin
                    chk("dm wr addr", 32'(bus.dm_addr), 32'(q[0].addr));
                    chk("dm_wdata", 32'(bus.dm_wdata), 32'(q[0].data));
                    void'(q.pop_front());
                    ret_m++;
                end
            end
            if (head() == K_EX && cyc == last_ack + 1) begin
                chk("Exec", 32'(Exec), 1);
                chk("IR", 32'(IR), 32'(q[0].ir));
                chk("IBR", 32'(IBR), 32'(q[0].ibr));
                chk("MBR", 32'(MBR), 32'(q[0].mbr));
                void'(q.pop_front());
                ret_m++;
            end else chk("stray Exec", 32'(Exec), 0);
            if (head() == K_HALT && cyc == last_ack + 1) begin
                void'(q.pop_front());
                halt_seen = 1;
            end
            chk("halted", 32'(halted), 32'(halt_seen));
            if (halt_seen) chk("requests in HALT", 32'({bus.pm_rd, bus.dm_rd, bus.dm_wr}), 0);
            p_pm_rd = bus.pm_rd; p_pm_valid = bus.pm_valid; p_pm_addr = bus.pm_addr;
            p_dm_rd = bus.dm_rd; p_dm_wr = bus.dm_wr; p_dm_valid = bus.dm_valid;
            p_dm_addr = bus.dm_addr; p_dm_wdata = bus.dm_wdata;
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, " pm_rd"}, 32'(bus.pm_rd), 0);
        chk({tag, " dm_rd/wr"}, 32'({bus.dm_rd, bus.dm_wr}), 0);
        chk({tag, " Exec"}, 32'(Exec), 0);
        chk({tag, " halted"}, 32'(halted), 0);
        chk({tag, " PC"}, 32'(bus.pm_addr), 0);
        chk({tag, " IR/IBR/MBR"}, 32'({IR, IBR, MBR}), 0);
        chk({tag, " dm_wdata"}, 32'(bus.dm_wdata), 0);
`ifdef SEQ_RETIRE_CNT_EN
        chk({tag, " retired"}, 32'(retired), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 0; arst = 1; run = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset_checks("reset");
    endtask

    initial begin
        int late;
        bit got;
        #300000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        bit got;
        for (int a = 0; a < 256; a++) dm_mem[a] = 8'($urandom);
        for (int a = 8; a < 254; a += 2) begin
            case ($urandom_range(0, 6))
                0: pm_mem[a] = 8'h00;
                1: pm_mem[a] = 8'h08;
                2: pm_mem[a] = 8'h20;
                3: pm_mem[a] = 8'h21;
                4: pm_mem[a] = 8'h30;
                5: pm_mem[a] = 8'h31;
                default: pm_mem[a] = 8'($urandom_range(0, 254));
            endcase
            pm_mem[a+1] = 8'($urandom);
        end
        pm_mem[254] = 8'hFF; pm_mem[255] = 8'h5A;
        pm_mem[0] = 8'h00; pm_mem[1] = 8'h05;
        pm_mem[2] = 8'h08; pm_mem[3] = 8'h10;
        pm_mem[4] = 8'h30; pm_mem[5] = 8'h20;
        pm_mem[6] = 8'h00; pm_mem[7] = 8'h07;
        dm_mem[8'h10] = 8'h3C;
        pm_fix = 0; pm_d = 0; dm_fix = 2; dm_d = 2; spur = 0; ar_fix = 1; ar_val = 8'hA5;
        do_reset();

        // 1: zero-wait ADD_I 05, Exec in the third cycle
        @(posedge clk); #1;
        arst = 0; run = 1; mon_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1 Exec cycle 3", 32'(Exec), 1);
        chk("t1 IR", 32'(IR), 32'h00);
        chk("t1 IBR", 32'(IBR), 32'h05);
        chk("t1 PC", 32'(bus.pm_addr), 2);

        // 2: ADD_X 10 with two wait cycles on the data read
        late = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.dm_rd) begin
                chk("t2 dm_addr", 32'(bus.dm_addr), 32'h10);
                if (bus.dm_valid) got = 1; else late++;
            end
        end
        chk("t2 ack seen", 32'(got), 1);
        chk("t2 wait cycles", 32'(late), 2);
        @(negedge clk);
        chk("t2 Exec after ack", 32'(Exec), 1);
        chk("t2 MBR", 32'(MBR), 32'h3C);

        // 3: STORE_X 20 with AR=A5
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            chk("t3 no Exec", 32'(Exec), 0);
            if (bus.dm_wr && bus.dm_valid) got = 1;
        end
        chk("t3 store seen", 32'(got), 1);
        chk("t3 dm_addr", 32'(bus.dm_addr), 32'h20);
        chk("t3 dm_wdata", 32'(bus.dm_wdata), 32'hA5);
        @(negedge clk);
        chk("t3 next fetch", 32'({bus.pm_rd, bus.pm_addr}), 32'h106);

        // 4: drop run during FETCH_IMM
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.pm_rd && bus.pm_addr == 8'h07) begin run = 0; got = 1; end
        end
        chk("t4 imm fetch seen", 32'(got), 1);
        @(negedge clk);
        chk("t4 Exec", 32'(Exec), 1);
        repeat (3) begin
            @(negedge clk);
            chk("t4 idle pm_rd", 32'(bus.pm_rd), 0);
        end
        chk("t4 saved PC", 32'(bus.pm_addr), 8);
        run = 1;
        @(negedge clk);
        chk("t4 resume", 32'({bus.pm_rd, bus.pm_addr}), 32'h108);

        // random program through to the HALT at 0xFE
        pm_fix = -1; dm_fix = -1; spur = 1; ar_fix = 0;
        for (int n = 0; n < 8000 && !halt_seen; n++) begin
            @(posedge clk); #1;
            run = $urandom_range(0, 9) != 0;
        end
        chk("t5 halt reached", 32'(halt_seen), 1);
        repeat (3) begin
            @(negedge clk);
            chk("t5 halted", 32'(halted), 1);
            chk("t5 PC wrapped", 32'(bus.pm_addr), 0);
            chk("t5 no requests", 32'({bus.pm_rd, bus.dm_rd, bus.dm_wr}), 0);
        end
        do_reset();

        // 6: reset while a data read is pending
        pm_fix = 0; pm_d = 0; dm_fix = 10; dm_d = 10; spur = 0;
        @(posedge clk); #1;
        arst = 0; run = 1; mon_en = 1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.dm_rd) got = 1;
        end
        chk("t6 dm_rd seen", 32'(got), 1);
        mon_en = 0; arst = 1;
        @(negedge clk);
        chk("t6 dm_rd dropped", 32'(bus.dm_rd), 0);
        chk("t6 Exec", 32'(Exec), 0);
        chk("t6 pm_rd", 32'(bus.pm_rd), 0);
`ifdef SEQ_RETIRE_CNT_EN
        chk("t6 retired", 32'(retired), 0);
`endif
        model_reset();
        @(posedge clk); #1;
        arst = 0; run = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t6 idle", 32'({bus.pm_rd, bus.dm_rd, Exec}), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
